// File: rtl/fetch_queue.sv
// fetch_queue: issues one instruction fetch per PC value and buffers responses in order toward decode.
// Optional macro FETCH_PERF_EN adds issue/flush/full-stall performance counters.
module fetch_queue #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        pc_addr,
    output logic                     pc_enable,
    input  logic                     flush,
    output logic                     im_req,
    output logic [ADDR_W-1:0]        im_addr,
    input  logic [DATA_W-1:0]        im_rdata,
    input  logic                     im_rvalid,
    output logic                     id_valid,
    output logic [DATA_W-1:0]        id_inst,
    output logic [ADDR_W-1:0]        id_pc,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   q_count
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              perf_issue_cnt,
    output logic [31:0]              perf_flush_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DATA_W-1:0] inst_d [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              outstanding_q, outstanding_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;

    logic [OCC_W-1:0]  occupancy;
    logic              has_room;
    logic              full;
    logic              resp;
    logic              issue;
    logic              push;
    logic              pop;

    // In-flight request counts against capacity; a same-cycle pop is not credited.
    assign occupancy = OCC_W'(count_q) + OCC_W'(outstanding_q);
    assign has_room  = occupancy < OCC_W'(DEPTH);
    assign full      = count_q == CNT_W'(DEPTH);
    assign resp      = outstanding_q && im_rvalid;
    assign issue     = !flush && has_room && (!outstanding_q || (im_rvalid && !drop_q));
    assign push      = resp && !drop_q && !flush;
    assign pop       = (count_q != '0) && id_ready && !flush;

    // Strobes are gated only at the outputs so reset never enters a flop's data cone.
    assign im_req    = issue && !rst;
    assign pc_enable = (issue || flush) && !rst;
    assign im_addr   = pc_addr;

    assign id_valid  = count_q != '0;
    assign id_inst   = inst_q[head_q];
    assign id_pc     = pc_q[head_q];
    assign q_count   = count_q;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        req_pc_d      = req_pc_q;
        inst_d        = inst_q;
        pc_d          = pc_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                inst_d[tail_q] = im_rdata;
                pc_d[tail_q]   = req_pc_q;
                tail_d         = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // A response arriving under flush or drop is simply consumed.
        if (resp) begin
            drop_d = 1'b0;
        end else if (flush && outstanding_q) begin
            drop_d = 1'b1;
        end

        if (issue) begin
            outstanding_d = 1'b1;
            req_pc_d      = pc_addr;
        end else if (resp) begin
            outstanding_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            req_pc_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            req_pc_q      <= req_pc_d;
            inst_q        <= inst_d;
            pc_q          <= pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issue_d = perf_issue_q + 32'(issue);
        perf_flush_d = perf_flush_q + 32'(flush);
        perf_stall_d = perf_stall_q + 32'(!flush && !issue && full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_flush_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_flush_q <= perf_flush_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: PC + memory environment, queue-level reference model checked every cycle,
// and directed scenarios with literal expectations. FETCH_PERF_EN enables counter checks.
module tb_fetch_queue;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_enable;
    logic              flush;
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_rdata;
    logic              im_rvalid;
    logic              id_valid;
    logic [DATA_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;
    logic              id_ready;
    logic [CNT_W-1:0]  q_count;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_issue_cnt, perf_flush_cnt, perf_stall_cnt;
    int unsigned       pm_issue, pm_flush, pm_stall;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_enable(pc_enable), .flush(flush),
        .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_rvalid(im_rvalid),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready),
        .q_count(q_count)
`ifdef FETCH_PERF_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_flush_cnt(perf_flush_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    // reference model state
    ent_t        m_q[$];
    bit          m_out, m_drop;
    logic [31:0] m_req_pc;

    // environment state
    logic [31:0] env_pc, br_target;
    int          lat;
    mreq_t       mem_q[$];

    // per-cycle capture from the compare process
    bit          c_rst, c_flush, c_issue, c_pop, c_req, c_pcen;
    logic [31:0] c_addr;
    int          cnt;
    bit          e_issue;

    logic [31:0] req_log[$], pop_pc_log[$], pop_inst_log[$];
    int          req_cyc[$], pop_cyc[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'hC000_0000 | a;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int at_i(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        cyc++;
        cnt = m_q.size();
        if (rst) begin
            chk("rst_im_req", im_req, 0);
            chk("rst_pc_enable", pc_enable, 0);
            chk("rst_id_valid", id_valid, 0);
            chk("rst_q_count", q_count, 0);
            chk("rst_id_inst", id_inst, 0);
            chk("rst_id_pc", id_pc, 0);
            c_issue = 1'b0;
            c_pop   = 1'b0;
`ifdef FETCH_PERF_EN
            pm_issue = 0; pm_flush = 0; pm_stall = 0;
            chk("rst_perf_issue", perf_issue_cnt, 0);
            chk("rst_perf_flush", perf_flush_cnt, 0);
            chk("rst_perf_stall", perf_stall_cnt, 0);
`endif
        end else begin
            e_issue = !flush && (cnt + int'(m_out)) < int'(DEPTH) && (!m_out || (im_rvalid && !m_drop));
            chk("im_req", im_req, e_issue);
            chk("pc_enable", pc_enable, e_issue || flush);
            if (e_issue) chk("im_addr", im_addr, env_pc);
            chk("q_count", q_count, cnt);
            chk("id_valid", id_valid, cnt != 0);
            if (cnt != 0) begin
                chk("id_pc", id_pc, m_q[0].pc);
                chk("id_inst", id_inst, m_q[0].inst);
            end
            c_issue = e_issue;
            c_pop   = (cnt != 0) && id_ready && !flush;
            if (im_req) begin
                req_log.push_back(im_addr);
                req_cyc.push_back(cyc);
            end
            if (id_valid && id_ready && !flush) begin
                pop_pc_log.push_back(id_pc);
                pop_inst_log.push_back(id_inst);
                pop_cyc.push_back(cyc);
            end
`ifdef FETCH_PERF_EN
            chk("perf_issue", perf_issue_cnt, pm_issue);
            chk("perf_flush", perf_flush_cnt, pm_flush);
            chk("perf_stall", perf_stall_cnt, pm_stall);
            pm_issue += int'(e_issue);
            pm_flush += int'(flush);
            pm_stall += int'(!flush && !e_issue && cnt == int'(DEPTH));
`endif
        end
        c_rst   = rst;
        c_flush = flush;
        c_req   = im_req;
        c_addr  = im_addr;
        c_pcen  = pc_enable;
    end

    // Advance one clock: update the model from the cycle just ended, then the PC and memory.
    task automatic tick();
        bit resp;
        @(posedge clk);
        #1;
        if (!c_rst) begin
            resp = m_out && im_rvalid;
            if (flush) begin
                m_q.delete();
            end else begin
                if (c_pop) void'(m_q.pop_front());
                if (resp && !m_drop) m_q.push_back('{pc: m_req_pc, inst: inst_of(m_req_pc)});
            end
            if (resp) m_drop = 1'b0;
            else if (flush && m_out) m_drop = 1'b1;
            if (c_issue) begin
                m_out    = 1'b1;
                m_req_pc = env_pc;
            end else if (resp) begin
                m_out = 1'b0;
            end
        end
        if (c_pcen) env_pc = c_flush ? br_target : env_pc + 32'd1;
        if (c_req) mem_q.push_back('{addr: c_addr, due: lat});
        for (int i = 0; i < mem_q.size(); i++) mem_q[i].due = mem_q[i].due - 1;
        im_rvalid = 1'b0;
        im_rdata  = 32'hDEAD_BEEF;
        if (mem_q.size() > 0 && mem_q[0].due <= 0) begin
            im_rvalid = 1'b1;
            im_rdata  = inst_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        pc_addr = env_pc;
    endtask

    task automatic clear_logs();
        req_log.delete(); pop_pc_log.delete(); pop_inst_log.delete();
        req_cyc.delete(); pop_cyc.delete();
    endtask

    // Reset is applied mid-cycle; responses already in the memory stay in flight.
    task automatic do_reset(input int n);
        rst = 1'b1;
        flush = 1'b0;
        m_q.delete();
        m_out = 1'b0;
        m_drop = 1'b0;
        env_pc = '0;
        pc_addr = '0;
        #1;
        chk("rst_async_im_req", im_req, 0);
        chk("rst_async_pc_enable", pc_enable, 0);
        chk("rst_async_id_valid", id_valid, 0);
        chk("rst_async_q_count", q_count, 0);
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input logic [31:0] a, input string nm);
        int n = 0;
        tick();
        while (!(c_req && c_addr == a) && n < 60) begin
            tick();
            n++;
        end
        chk({nm, "_seen"}, c_req && c_addr == a, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; id_ready = 1'b1; pc_addr = '0;
        im_rvalid = 1'b0; im_rdata = '0; lat = 1; br_target = '0; env_pc = '0;
        do_reset(3);

        // streaming, latency 1
        clear_logs();
        repeat (8) tick();
        for (int i = 0; i < 4; i++) begin
            chk("t1_im_addr_seq", at(req_log, i), 32'(i));
            chk("t1_id_pc_seq", at(pop_pc_log, i), 32'(i));
            chk("t1_id_inst_seq", at(pop_inst_log, i), 32'hC000_0000 + 32'(i));
        end
        chk("t1_first_valid_lat", 64'(at_i(pop_cyc, 0) - at_i(req_cyc, 0)), 64'(2));
        chk("t1_no_gaps", 64'(at_i(pop_cyc, 3) - at_i(pop_cyc, 0)), 64'(3));

        // decode stalled: queue fills, fetch stops
        id_ready = 1'b0;
        do_reset(3);
        clear_logs();
        repeat (10) tick();
        chk("t2_q_full", q_count, 4);
        chk("t2_full_no_req", c_req, 0);
        chk("t2_full_no_pcen", c_pcen, 0);
        id_ready = 1'b1;
        clear_logs();
        repeat (6) tick();
        chk("t2_first_pop_pc", at(pop_pc_log, 0), 32'h0);
        chk("t2_second_pop_pc", at(pop_pc_log, 1), 32'h1);
        chk("t2_resume_addr", at(req_log, 0), 32'h4);

        // flush with request to 5 in flight, response one cycle later
        lat = 2;
        do_reset(3);
        clear_logs();
        wait_req(32'h5, "t3_req5");
        flush = 1'b1;
        br_target = 32'h40;
        tick();
        flush = 1'b0;
        chk("t3_flush_pcen", c_pcen, 1);
        chk("t3_q_cleared", q_count, 0);
        clear_logs();
        repeat (8) tick();
        chk("t3_next_req", at(req_log, 0), 32'h40);
        chk("t3_next_pc", at(pop_pc_log, 0), 32'h40);
        chk("t3_next_inst", at(pop_inst_log, 0), 32'hC000_0040);

        // flush coinciding with the response
        lat = 1;
        do_reset(3);
        clear_logs();
        wait_req(32'h3, "t4_req3");
        flush = 1'b1;
        br_target = 32'h80;
        tick();
        flush = 1'b0;
        clear_logs();
        tick();
        chk("t4_issue_after_flush", c_req, 1);
        chk("t4_issue_addr", c_addr, 32'h80);
        repeat (5) tick();
        chk("t4_next_pc", at(pop_pc_log, 0), 32'h80);

        // latency 3, then reset with a request in flight
        lat = 3;
        do_reset(4);
        clear_logs();
        wait_req(32'h2, "t5_req2");
        chk("t5_spacing_a", 64'(at_i(req_cyc, 1) - at_i(req_cyc, 0)), 64'(3));
        chk("t5_spacing_b", 64'(at_i(req_cyc, 2) - at_i(req_cyc, 1)), 64'(3));
        do_reset(2);
        clear_logs();
        repeat (12) tick();
        chk("t5_post_rst_pc", at(pop_pc_log, 0), 32'h0);
        chk("t5_post_rst_inst", at(pop_inst_log, 0), 32'hC000_0000);

        // mixed traffic with back-to-back flushes
        lat = 2;
        do_reset(4);
        for (int i = 0; i < 40; i++) begin
            id_ready = (i % 3) != 0;
            flush = (i == 15 || i == 16 || i == 30);
            if (i == 15) br_target = 32'h100;
            if (i == 30) br_target = 32'h200;
            tick();
            if (c_flush) begin
                chk("t6_flush_pcen", c_pcen, 1);
                chk("t6_flush_noreq", c_req, 0);
            end
        end
        flush = 1'b0;
        id_ready = 1'b1;
        repeat (10) tick();

`ifdef FETCH_PERF_EN
        // 10 issues, 2 flushes, 3 full-stall cycles
        lat = 1;
        id_ready = 1'b0;
        do_reset(3);
        repeat (8) tick();
        flush = 1'b1;
        repeat (2) tick();
        flush = 1'b0;
        id_ready = 1'b1;
        repeat (6) tick();
        chk("perf_issue_lit", perf_issue_cnt, 10);
        chk("perf_flush_lit", perf_flush_cnt, 2);
        chk("perf_stall_lit", perf_stall_cnt, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Issues one instruction-memory read per PC value and drives pc_enable back to the PC so it advances only when a fetch is actually issued.
- Buffers returned instructions with their PC in a small in-order queue toward decode, using a valid/ready handshake.
- On a taken branch, flushes queued and in-flight fetches.

Parameters:
- ADDR_W, 32, instruction address width (matches PC width; word addressing, PC steps by 1).
- DATA_W, 32, instruction word width.
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- pc_addr  input  ADDR_W  current PC value
- pc_enable  output  1  PC advance/load strobe
- flush  input  1  taken branch; same signal the PC uses to load the target
- im_req  output  1  instruction memory read request, one-cycle pulse
- im_addr  output  ADDR_W  read address
- im_rdata  input  DATA_W  read data
- im_rvalid  input  1  read data valid; one cycle or more after im_req; responses in order
- id_valid  output  1  queue head valid toward decode
- id_inst  output  DATA_W  head instruction
- id_pc  output  ADDR_W  head PC
- id_ready  input  1  decode accepts head
- q_count  output  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (async): queue empty, q_count=0, outstanding=0, drop=0, req_pc=0. id_valid, im_req and pc_enable all 0. id_inst and id_pc are 0.
- Internal state:
  - outstanding: a request is in flight; at most 1.
  - drop: the in-flight response must be discarded.
  - req_pc: the address of the in-flight request.
- Issue condition: !flush && (q_count + outstanding) < DEPTH && (!outstanding || (im_rvalid && !drop)).
  - The pop in the same cycle is ignored, so the full check is conservative.
- On issue (combinational strobes):
  - im_req=1 and im_addr=pc_addr.
  - pc_enable=1, so the PC increments at the same edge.
  - At the edge, req_pc<=pc_addr and outstanding<=1.
- pc_enable = issue || flush. A flush must raise pc_enable so the PC loads the branch target.
- im_req=0 whenever flush=1.
- Response with outstanding=1, im_rvalid=1:
  - If drop=1 or flush=1: data is discarded, drop<=0.
  - Otherwise {req_pc, im_rdata} is pushed at the tail.
  - In both cases outstanding<=0 unless a new issue occurs in the same cycle.
- im_rvalid while outstanding=0 is ignored. This covers stale responses after reset.
- Pop: id_valid && id_ready && !flush. The head advances at the edge.
- Push and pop in the same cycle: q_count is unchanged.
- id_valid = (q_count != 0). id_inst and id_pc are the head entry, registered storage with no bypass. Empty queue means id_valid=0 and the data is don't-care (bench checks only when valid).
- Flush:
  - Queue cleared at the edge (q_count<=0, pointers reset).
  - No pop and no push that cycle.
  - If outstanding=1 and im_rvalid=0: drop<=1.
  - A flush while drop=1 keeps drop=1.
- Back-to-back flushes: each cycle asserts pc_enable; no fetch is issued while flush=1.
- Pointers wrap modulo DEPTH. Queue full (q_count=DEPTH) blocks issue; pc_enable stays 0 and the PC holds.
- Steady-state throughput with 1-cycle memory latency and id_ready=1: one instruction per cycle after the first response.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds outputs:
  - perf_issue_cnt [31:0]: increments on each issue.
  - perf_flush_cnt [31:0]: increments on each flush cycle.
  - perf_stall_cnt [31:0]: increments each cycle with !flush, issue=0 and q_count=DEPTH.
- All three reset to 0 and wrap at 2^32.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, pc_addr follows a model PC starting at 0, memory latency 1, id_ready=1 -> im_addr sequence 0,1,2,3; id_pc 0,1,2,3 with matching id_inst in order; no gaps after the first valid.
- id_ready=0 with DEPTH=4 -> q_count reaches 4, then im_req=0 and pc_enable=0. Raise id_ready -> head id_pc=0 pops first and issuing resumes.
- Flush asserted while a request to address 5 is in flight (response arrives next cycle) -> pc_enable=1 during flush, q_count=0 next cycle, the response for address 5 is discarded, and the next id_pc equals the branch target (e.g. 0x40).
- Flush asserted in the same cycle as im_rvalid -> data discarded, drop stays 0, and the next fetch issues the cycle after flush deasserts.
- Memory latency 3 cycles -> only one request is outstanding at a time and im_req pulses are spaced accordingly. Reset asserted mid-flight -> all outputs return to 0 immediately; a late im_rvalid is ignored.
- With FETCH_PERF_EN: 10 issues, 2 flushes, 3 full-stall cycles -> counters read 10, 2, 3.
